// File: rtl/plab4_net_router_input_ctrl_sep_pkg.sv
// Shared ring-router definitions: output port indices and the route function
// used by the input ctrl, the output ctrl and sibling routers.
package plab4_net_router_input_ctrl_sep_pkg;

  localparam logic [1:0] PORT_PREV = 2'd0;
  localparam logic [1:0] PORT_TERM = 2'd1;
  localparam logic [1:0] PORT_NEXT = 2'd2;
  localparam int         NUM_PORTS = 3;

  // Forward distance wraps around the ring; an exact half-ring tie goes forward.
  function automatic logic [1:0] route_port(input int dest, input int router_id,
                                            input int num_routers);
    int         fwd;
    logic [1:0] port;
    fwd = dest + num_routers - router_id;
    if (fwd >= num_routers) fwd = fwd - num_routers;
    if (dest == router_id)            port = PORT_TERM;
    else if (fwd <= num_routers / 2)  port = PORT_NEXT;
    else                              port = PORT_PREV;
    return port;
  endfunction

endpackage

// File: rtl/plab4_net_DomainQueue_sep.sv
// Circular-buffer FIFO carrying {domain, msg} per entry; head is read
// combinationally from the deq pointer, with no enqueue-to-head bypass.
module plab4_net_DomainQueue_sep #(
  parameter int p_msg_nbits   = 44,
  parameter int p_num_entries = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  input  logic                   enq_domain,
  output logic                   deq_val,
  input  logic                   deq_en,
  output logic [p_msg_nbits-1:0] deq_msg,
  output logic                   deq_domain
);

  localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
  localparam int CW = $clog2(p_num_entries + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(p_num_entries);

  logic [p_msg_nbits:0] mem_q [p_num_entries];
  logic [PW-1:0]        enq_ptr_q, enq_ptr_d;
  logic [PW-1:0]        deq_ptr_q, deq_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_enq, do_deq;

  assign enq_rdy = (count_q != FULL_COUNT);
  assign deq_val = (count_q != '0);
  assign do_enq  = enq_val && enq_rdy;
  assign do_deq  = deq_en && deq_val;

  assign {deq_domain, deq_msg} = mem_q[deq_ptr_q];

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (do_enq) enq_ptr_d = enq_ptr_q + PW'(1);
    if (do_deq) deq_ptr_d = deq_ptr_q + PW'(1);
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_enq) mem_q[enq_ptr_q] <= {enq_domain, enq_msg};
  end

endmodule

// File: rtl/plab4_net_router_input_ctrl_sep.sv
// Ring-router input port: buffers {domain, msg}, routes the head message to
// one of three output ctrls and dequeues it on the matching grant.
module plab4_net_router_input_ctrl_sep
  import plab4_net_router_input_ctrl_sep_pkg::*;
#(
  parameter int p_msg_nbits   = 44,
  parameter int p_dest_nbits  = 2,
  parameter int p_num_routers = 4,
  parameter int p_router_id   = 0,
  parameter int p_num_entries = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_msg_nbits-1:0] in_msg,
  input  logic                   in_domain,
  output logic                   reqs_p0,
  output logic                   reqs_p1,
  output logic                   reqs_p2,
  output logic                   reqs_domain,
  input  logic                   grants_p0,
  input  logic                   grants_p1,
  input  logic                   grants_p2,
  output logic [p_msg_nbits-1:0] out_msg,
  output logic                   out_domain
);

  logic                    head_val;
  logic [p_msg_nbits-1:0]  head_msg;
  logic                    head_domain;
  logic [p_dest_nbits-1:0] head_dest;
  logic [1:0]              head_port;
  logic                    deq_en;

  plab4_net_DomainQueue_sep #(
    .p_msg_nbits   (p_msg_nbits),
    .p_num_entries (p_num_entries)
  ) queue (
    .clk        (clk),
    .reset      (reset),
    .enq_val    (in_val),
    .enq_rdy    (in_rdy),
    .enq_msg    (in_msg),
    .enq_domain (in_domain),
    .deq_val    (head_val),
    .deq_en     (deq_en),
    .deq_msg    (head_msg),
    .deq_domain (head_domain)
  );

  assign head_dest = head_msg[p_msg_nbits-1 -: p_dest_nbits];
  assign head_port = route_port(32'(head_dest), p_router_id, p_num_routers);

  always_comb begin
    reqs_p0     = 1'b0;
    reqs_p1     = 1'b0;
    reqs_p2     = 1'b0;
    reqs_domain = 1'b0;
    out_domain  = 1'b0;
    out_msg     = '0;
    // Stale RAM contents must not leak onto the outputs while empty.
    if (head_val) begin
      reqs_p0     = (head_port == PORT_PREV);
      reqs_p1     = (head_port == PORT_TERM);
      reqs_p2     = (head_port == PORT_NEXT);
      reqs_domain = head_domain;
      out_domain  = head_domain;
      out_msg     = head_msg;
    end
  end

  assign deq_en = (reqs_p0 && grants_p0) || (reqs_p1 && grants_p1) ||
                  (reqs_p2 && grants_p2);

endmodule

// File: tb/tb_plab4_net_router_input_ctrl_sep.sv
// Directed bench: router id 0 and id 3 instances driven with the same messages.
module tb_plab4_net_router_input_ctrl_sep;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic [43:0] in_msg;
  logic        in_domain;
  logic [2:0]  ga, gb;
  logic        rdy_a, rdy_b;
  logic        a_p0, a_p1, a_p2, a_dom, a_odom;
  logic        b_p0, b_p1, b_p2, b_dom, b_odom;
  logic [43:0] a_msg, b_msg;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [2:0]  exp_a [4];
  logic [2:0]  exp_b [4];
  logic [43:0] sm    [6];
  logic        sd    [6];
  logic [1:0]  sdest [6];

  always #5 clk = ~clk;

  plab4_net_router_input_ctrl_sep #(.p_router_id(0)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_a), .in_msg(in_msg),
    .in_domain(in_domain), .reqs_p0(a_p0), .reqs_p1(a_p1), .reqs_p2(a_p2),
    .reqs_domain(a_dom), .grants_p0(ga[0]), .grants_p1(ga[1]), .grants_p2(ga[2]),
    .out_msg(a_msg), .out_domain(a_odom)
  );

  plab4_net_router_input_ctrl_sep #(.p_router_id(3)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_b), .in_msg(in_msg),
    .in_domain(in_domain), .reqs_p0(b_p0), .reqs_p1(b_p1), .reqs_p2(b_p2),
    .reqs_domain(b_dom), .grants_p0(gb[0]), .grants_p1(gb[1]), .grants_p2(gb[2]),
    .out_msg(b_msg), .out_domain(b_odom)
  );

  function automatic logic [43:0] mk(input logic [1:0] d, input logic [41:0] p);
    return {d, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both instances idle: empty, ready, all outputs at zero.
  task automatic chk_empty(input string tag);
    chk({tag, " rdy_a"}, 64'(rdy_a), 64'(1));
    chk({tag, " rdy_b"}, 64'(rdy_b), 64'(1));
    chk({tag, " reqs_a"}, 64'({a_p2, a_p1, a_p0}), 64'(0));
    chk({tag, " reqs_b"}, 64'({b_p2, b_p1, b_p0}), 64'(0));
    chk({tag, " dom_a"}, 64'({a_dom, a_odom}), 64'(0));
    chk({tag, " msg_a"}, 64'(a_msg), 64'(0));
    chk({tag, " msg_b"}, 64'(b_msg), 64'(0));
  endtask

  task automatic chk_head(input string tag, input logic [43:0] m, input logic d);
    chk({tag, " msg_a"}, 64'(a_msg), 64'(m));
    chk({tag, " dom_a"}, 64'({a_dom, a_odom}), 64'({d, d}));
    chk({tag, " reqs_a"}, 64'({a_p2, a_p1, a_p0}), 64'(exp_a[m[43:42]]));
    chk({tag, " reqs_b"}, 64'({b_p2, b_p1, b_p0}), 64'(exp_b[m[43:42]]));
    chk({tag, " dom_b"}, 64'(b_odom), 64'(d));
  endtask

  initial begin
    // Hand-computed routes {p2,p1,p0} per dest: id 0 and id 3 on a 4-router ring.
    exp_a[0] = 3'b010; exp_a[1] = 3'b100; exp_a[2] = 3'b100; exp_a[3] = 3'b001;
    exp_b[0] = 3'b100; exp_b[1] = 3'b100; exp_b[2] = 3'b001; exp_b[3] = 3'b010;
    for (int i = 0; i < 6; i++) begin
      sdest[i] = 2'(i + 1);
      sd[i]    = 1'(i);
      sm[i]    = mk(sdest[i], 42'(32'h5A00 + i));
    end

    reset = 1'b1; in_val = 1'b0; in_msg = '0; in_domain = 1'b0; ga = '0; gb = '0;
    tick(); tick();
    reset = 1'b0;
    chk_empty("reset");

    // Terminal message with domain 1; not visible before the enqueue edge.
    in_val = 1'b1; in_msg = mk(2'd0, 42'h111); in_domain = 1'b1;
    chk("nobypass reqs_a", 64'({a_p2, a_p1, a_p0}), 64'(0));
    tick();
    in_val = 1'b0;
    chk_head("term", mk(2'd0, 42'h111), 1'b1);
    ga = 3'b010; gb = 3'b100;
    tick();
    ga = '0; gb = '0;
    chk_empty("term drained");

    // Route of each remaining dest, including the half-ring tie.
    for (int d = 1; d < 4; d++) begin
      in_val = 1'b1; in_msg = mk(2'(d), 42'(32'h200 + d)); in_domain = 1'b0;
      tick();
      in_val = 1'b0;
      chk_head($sformatf("route d%0d", d), mk(2'(d), 42'(32'h200 + d)), 1'b0);
      ga = exp_a[d]; gb = exp_b[d];
      tick();
      ga = '0; gb = '0;
    end
    chk_empty("route drained");

    // Fill to full, then offer a message on the same cycle as a dequeue.
    in_val = 1'b1; in_msg = mk(2'd1, 42'h301); in_domain = 1'b0;
    tick();
    in_msg = mk(2'd1, 42'h302); in_domain = 1'b1;
    tick();
    in_msg = mk(2'd3, 42'h303); in_domain = 1'b1;
    chk("full rdy_a", 64'(rdy_a), 64'(0));
    chk("full rdy_b", 64'(rdy_b), 64'(0));
    chk_head("full head", mk(2'd1, 42'h301), 1'b0);
    ga = exp_a[1]; gb = exp_b[1];
    tick();
    ga = '0; gb = '0;
    chk_head("after deq", mk(2'd1, 42'h302), 1'b1);
    chk("after deq rdy_a", 64'(rdy_a), 64'(1));
    tick();
    in_val = 1'b0;
    chk("refull rdy_a", 64'(rdy_a), 64'(0));
    chk_head("refull head", mk(2'd1, 42'h302), 1'b1);
    ga = exp_a[1]; gb = exp_b[1];
    tick();
    chk_head("late msg", mk(2'd3, 42'h303), 1'b1);
    ga = exp_a[3]; gb = exp_b[3];
    tick();
    ga = '0; gb = '0;
    chk_empty("fill drained");

    // Streaming: enqueue one and dequeue one every cycle, domains alternating.
    for (int c = 0; c <= 6; c++) begin
      in_val = (c < 6);
      if (c < 6) begin
        in_msg = sm[c]; in_domain = sd[c];
      end
      if (c > 0) begin
        chk_head($sformatf("stream %0d", c - 1), sm[c-1], sd[c-1]);
        chk($sformatf("stream %0d rdy_a", c - 1), 64'(rdy_a), 64'(1));
        ga = exp_a[sdest[c-1]]; gb = exp_b[sdest[c-1]];
      end
      tick();
    end
    in_val = 1'b0; ga = '0; gb = '0;
    chk_empty("stream drained");

    // Reset with two messages buffered discards them.
    in_val = 1'b1; in_msg = mk(2'd2, 42'h401); in_domain = 1'b1;
    tick(); tick();
    in_val = 1'b0;
    chk("pre-reset rdy_a", 64'(rdy_a), 64'(0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_empty("mid reset");
    ga = 3'b111; gb = 3'b111;
    tick();
    ga = '0; gb = '0;
    chk_empty("grant after reset");
    in_val = 1'b1; in_msg = mk(2'd3, 42'h501); in_domain = 1'b0;
    tick();
    in_val = 1'b0;
    chk_head("post reset", mk(2'd3, 42'h501), 1'b0);
    chk("post reset rdy_a", 64'(rdy_a), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
